// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM state type and counter sizing for the serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold WIDTH itself so it never wraps mid-operation
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result bundle of serial_add_ctrl; sub exists only with SERIAL_ADD_SUB_EN
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// rtl/serial_add_ctrl_fa_cell.sv - single-bit full adder shared across all bit positions
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first, one bit per clock
// Optional subtract mode enabled by SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy;

  logic             accept;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             cell_s;
  logic             cell_co;

  assign accept = (state_q == IDLE) && bus.start;

  // Subtraction is a + ~b + 1, so only the loaded B word and carry differ
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  fa_cell u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done is registered so it lands in the cycle after DONE, when the result is settled
  always_comb begin
    busy   = (state_q != IDLE);
    done_d = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = bus.a;
      b_d     = b_load;
      carry_d = c_load;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = {cell_s, res_q[WIDTH-1:1]};
      carry_d = cell_co;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.sum  = res_q;
  assign bus.cout = carry_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width in bits; legal range is 2..64.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request to begin one addition; sampled only in IDLE.
REQ-005 Port a, input, WIDTH bits: operand A; captured on an accepted start.
REQ-006 Port b, input, WIDTH bits: operand B; captured on an accepted start.
REQ-007 Port cin, input, 1 bit: carry-in; captured on an accepted start.
REQ-008 Port sub, input, 1 bit: subtract request; present only when SERIAL_ADD_SUB_EN is defined.
REQ-009 Port busy, output, 1 bit: high in RUN and DONE.
REQ-010 Port done, output, 1 bit: single-cycle pulse that marks the result as valid.
REQ-011 Port sum, output, WIDTH bits: result word.
REQ-012 Port cout, output, 1 bit: final carry-out.

Function
REQ-013 The controller SHALL time-share one 1-bit full-adder cell across all WIDTH bit positions, LSB first, one bit per clock.
REQ-014 The FSM SHALL have exactly three states, with these transitions:
- IDLE -> RUN on start=1.
- RUN -> DONE after exactly WIDTH RUN cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 An accepted start in IDLE SHALL load the operand shift registers from a and b, load the carry register from cin, and clear the bit counter.
REQ-016 In each RUN cycle the controller SHALL:
- feed the LSBs of the A and B shift registers and the carry register to the cell;
- shift the cell sum bit into the MSB of the result register, with the register shifting right;
- store the cell carry-out in the carry register;
- increment the bit counter.
REQ-017 Latency: with start sampled at edge 0, done SHALL be high for the single cycle following edge WIDTH+1.
REQ-018 sum and cout SHALL equal the WIDTH-bit result and the carry-out of a+b+cin, valid from done onward and held until the next accepted start.
REQ-019 start SHALL be ignored while busy=1; in-flight operands and the cycle count SHALL be unaffected.
REQ-020 Changes on a, b, cin or sub after acceptance SHALL NOT affect the in-flight result.
REQ-021 The counter width SHALL be $clog2(WIDTH+1) bits, so the counter never wraps within an operation.
REQ-022 start held high continuously SHALL launch back-to-back operations with exactly one IDLE cycle between the DONE cycle and the next RUN.

Reset
REQ-023 rst_n=0 SHALL immediately force:
- state = IDLE;
- busy = 0, done = 0, sum = 0, cout = 0;
- counter, carry register and shift registers = 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL behave as the first operation.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN defined:
- the sub port exists;
- on an accepted start with sub=1, the B shift register loads ~b and the carry register loads 1, ignoring cin;
- result is a-b and cout=1 means no borrow.
REQ-026 Macro SERIAL_ADD_SUB_EN undefined: the sub port is absent and the block performs addition only.

Structure
REQ-027 Package serial_add_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- a constant function returning the counter width for a given WIDTH.
REQ-028 The 1-bit cell SHALL be a separate combinational sub-module, fa_cell (ports a, b, ci, s, co), instantiated exactly once.

Verification
REQ-029 Scenario 1: WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, done exactly 9 cycles after the start edge.
REQ-030 Scenario 2: a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1; then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
REQ-031 Scenario 3: start pulsed during RUN with different operands -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-032 Scenario 4: rst_n pulsed low at RUN cycle 4 -> outputs 0 immediately, no done pulse; the next operation 0x03+0x04 -> sum=0x07.
REQ-033 Scenario 5 (SERIAL_ADD_SUB_EN): sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
REQ-034 Scenario 6: start held high for 30 cycles -> done pulses every WIDTH+2 cycles, each with a correct result.
